// File: rtl/icram_fill_if.sv
// Bundle of fetch, line-fill and array-side signals for the icram fill controller.
// The controller uses the slave view; the fetch unit, bus interface and array use the master view.
interface icram_fill_if #(
    parameter int IC_MSB = 8
);
    localparam int AW = IC_MSB - 2;

    logic          fetch_req;
    logic [AW-1:0] fetch_adr;
    logic          fetch_gnt;
    logic          fetch_rd_vld;
    logic          fill_start;
    logic [AW-1:0] fill_adr;
    logic          fill_data_vld;
    logic [31:0]   fill_data;
    logic          fill_err;
    logic          fill_busy;
    logic          fill_done;
    logic          fill_abort;
    logic          init_done;
    logic [AW-1:0] ram_adr;
    logic [31:0]   ram_di;
    logic [1:0]    ram_we;
    logic          ram_enable;

    modport slave (
        input  fetch_req, fetch_adr, fill_start, fill_adr, fill_data_vld, fill_data, fill_err,
        output fetch_gnt, fetch_rd_vld, fill_busy, fill_done, fill_abort, init_done,
               ram_adr, ram_di, ram_we, ram_enable
    );

    modport master (
        output fetch_req, fetch_adr, fill_start, fill_adr, fill_data_vld, fill_data, fill_err,
        input  fetch_gnt, fetch_rd_vld, fill_busy, fill_done, fill_abort, init_done,
               ram_adr, ram_di, ram_we, ram_enable
    );
endinterface

// File: rtl/icram_fill_ctl.sv
// Sequencer for the icache data RAM: post-reset clear sweep, 32-bit-per-cycle line fills,
// and fetch reads that take any cycle a fill beat is not being written.
module icram_fill_ctl #(
    parameter int IC_MSB = 8,
    parameter int BEATS  = 4
) (
    input  logic        clk,
    input  logic        reset_l,
    icram_fill_if.slave bus
);
    localparam int AW = IC_MSB - 2;
    localparam int CW = IC_MSB - 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [AW-1:0] LINE_MASK = AW'(BEATS / 2 - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {INIT, IDLE, FILL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] ram_adr_q, ram_adr_d;
    logic [31:0]   ram_di_q, ram_di_d;
    logic [1:0]    ram_we_q, ram_we_d;
    logic          ram_enable_q, ram_enable_d;
    logic          fetch_rd_vld_q, fetch_rd_vld_d;
    logic          fill_busy_q, fill_busy_d;
    logic          fill_done_q, fill_done_d;
    logic          fill_abort_q, fill_abort_d;
    logic          init_done_q, init_done_d;
    logic          fill_wr;
    logic          gnt;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        beat_d         = beat_q;
        base_d         = base_q;
        ram_adr_d      = ram_adr_q;
        ram_di_d       = ram_di_q;
        ram_we_d       = 2'b00;
        ram_enable_d   = 1'b0;
        fetch_rd_vld_d = 1'b0;
        fill_done_d    = 1'b0;
        fill_abort_d   = 1'b0;
        // A fill beat owns the array this cycle; an erroring beat is dropped and frees it.
        fill_wr        = (state_q == FILL) & bus.fill_data_vld & ~bus.fill_err;
        gnt            = bus.fetch_req & (state_q != INIT) & ~fill_wr;

        case (state_q)
            INIT: begin
                ram_adr_d    = cnt_q[CW-1:1];
                ram_di_d     = '0;
                ram_we_d     = cnt_q[0] ? 2'b01 : 2'b10;
                ram_enable_d = 1'b1;
                cnt_d        = cnt_q + CW'(1);
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.fill_start) begin
                    state_d = FILL;
                    base_d  = bus.fill_adr & ~LINE_MASK;
                    beat_d  = '0;
                end
            end
            FILL: begin
                if (bus.fill_err) begin
                    state_d      = IDLE;
                    fill_abort_d = 1'b1;
                end else if (bus.fill_data_vld) begin
                    // base has its in-line bits cleared, so this never carries out of the line
                    ram_adr_d    = base_q + AW'(beat_q >> 1);
                    ram_di_d     = bus.fill_data;
                    ram_we_d     = beat_q[0] ? 2'b01 : 2'b10;
                    ram_enable_d = 1'b1;
                    beat_d       = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d     = IDLE;
                        fill_done_d = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase

        if (gnt) begin
            ram_adr_d      = bus.fetch_adr;
            ram_we_d       = 2'b00;
            ram_enable_d   = 1'b1;
            fetch_rd_vld_d = 1'b1;
        end

        fill_busy_d = (state_d == FILL);
        // Rises one cycle after the final sweep write reaches the array.
        init_done_d = init_done_q | (state_q != INIT);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q        <= INIT;
            cnt_q          <= '0;
            beat_q         <= '0;
            base_q         <= '0;
            ram_adr_q      <= '0;
            ram_di_q       <= '0;
            ram_we_q       <= 2'b00;
            ram_enable_q   <= 1'b0;
            fetch_rd_vld_q <= 1'b0;
            fill_busy_q    <= 1'b0;
            fill_done_q    <= 1'b0;
            fill_abort_q   <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            beat_q         <= beat_d;
            base_q         <= base_d;
            ram_adr_q      <= ram_adr_d;
            ram_di_q       <= ram_di_d;
            ram_we_q       <= ram_we_d;
            ram_enable_q   <= ram_enable_d;
            fetch_rd_vld_q <= fetch_rd_vld_d;
            fill_busy_q    <= fill_busy_d;
            fill_done_q    <= fill_done_d;
            fill_abort_q   <= fill_abort_d;
            init_done_q    <= init_done_d;
        end
    end

    assign bus.fetch_gnt    = gnt;
    assign bus.fetch_rd_vld = fetch_rd_vld_q;
    assign bus.fill_busy    = fill_busy_q;
    assign bus.fill_done    = fill_done_q;
    assign bus.fill_abort   = fill_abort_q;
    assign bus.init_done    = init_done_q;
    assign bus.ram_adr      = ram_adr_q;
    assign bus.ram_di       = ram_di_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.ram_enable   = ram_enable_q;
endmodule

// File: tb/tb_icram_fill_ctl.sv
// Scoreboard bench for icram_fill_ctl: a cycle-level reference model predicts every array
// access and pulse; a separate monitor pops and compares whenever the controller drives one.
module tb_icram_fill_ctl;
    localparam int IC_MSB = 8;
    localparam int BEATS  = 4;
    localparam int AW     = IC_MSB - 2;
    localparam int SWEEP  = 2 ** (IC_MSB - 1);

    logic clk = 1'b0;
    logic reset_l = 1'b1;
    always #5 clk = ~clk;

    icram_fill_if #(.IC_MSB(IC_MSB)) bus ();
    icram_fill_ctl #(.IC_MSB(IC_MSB), .BEATS(BEATS)) dut (.clk(clk), .reset_l(reset_l), .bus(bus));

    typedef struct packed {
        logic [31:0]   cyc;
        logic          rdv;
        logic          done;
        logic          abort;
        logic          en;
        logic [1:0]    we;
        logic [AW-1:0] adr;
        logic [31:0]   di;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;

    // reference model state
    int            m_mode;   // 0 sweeping, 1 idle, 2 filling
    int            m_s, m_b;
    logic [AW-1:0] m_base, m_adr;
    logic [31:0]   m_di;
    bit            m_idone, m_arm, m_last_g;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_s = 0; m_b = 0; m_base = '0; m_adr = '0; m_di = '0;
        m_idone = 0; m_arm = 0; m_last_g = 0;
        q.delete();
    endtask

    // One clock of stimulus: check levels, drive inputs, check grant, predict the next-cycle access.
    task automatic step(input logic req, input logic [AW-1:0] fa, input logic st,
                        input logic [AW-1:0] sa, input logic vld, input logic [31:0] d,
                        input logic err);
        ev_t e;
        logic g;
        @(negedge clk);
        check("fill_busy", 32'(bus.fill_busy), 32'(m_mode == 2));
        check("init_done", 32'(bus.init_done), 32'(m_idone));
        bus.fetch_req = req; bus.fetch_adr = fa; bus.fill_start = st; bus.fill_adr = sa;
        bus.fill_data_vld = vld; bus.fill_data = d; bus.fill_err = err;
        #1;
        g = req && (m_mode != 0) && !(m_mode == 2 && vld && !err);
        check("fetch_gnt", 32'(bus.fetch_gnt), 32'(g));
        m_last_g = g;
        if (m_arm) m_idone = 1;
        e = '0;
        e.cyc = cyc + 1;
        e.adr = m_adr;
        e.di  = m_di;
        case (m_mode)
            0: begin
                e.en = 1; e.adr = AW'(m_s / 2); e.di = '0;
                e.we = (m_s % 2 == 1) ? 2'b01 : 2'b10;
                m_s++;
                if (m_s == SWEEP) begin m_mode = 1; m_arm = 1; end
            end
            1: if (st) begin
                m_mode = 2; m_b = 0;
                m_base = sa & ~AW'(BEATS / 2 - 1);
            end
            default: if (err) begin
                e.abort = 1; m_mode = 1;
            end else if (vld) begin
                e.en = 1; e.adr = m_base + AW'(m_b / 2); e.di = d;
                e.we = (m_b % 2 == 1) ? 2'b01 : 2'b10;
                if (m_b == BEATS - 1) begin e.done = 1; m_mode = 1; end
                m_b++;
            end
        endcase
        if (g) begin e.en = 1; e.we = 2'b00; e.adr = fa; e.rdv = 1; end
        m_adr = e.adr;
        m_di  = e.di;
        if (e.en || e.abort) q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, '0, 0);
    endtask

    task automatic check_reset_values();
        check("rst_ram_adr", 32'(bus.ram_adr), 0);
        check("rst_ram_di", bus.ram_di, 0);
        check("rst_ram_we", 32'(bus.ram_we), 0);
        check("rst_ram_enable", 32'(bus.ram_enable), 0);
        check("rst_fill_busy", 32'(bus.fill_busy), 0);
        check("rst_fill_done", 32'(bus.fill_done), 0);
        check("rst_fill_abort", 32'(bus.fill_abort), 0);
        check("rst_rd_vld", 32'(bus.fetch_rd_vld), 0);
        check("rst_init_done", 32'(bus.init_done), 0);
        check("rst_fetch_gnt", 32'(bus.fetch_gnt), 0);
    endtask

    // monitor: every cycle the controller touches the array or pulses, compare against the queue
    initial begin
        ev_t act, e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ram_enable || bus.fill_done || bus.fill_abort || bus.fetch_rd_vld) begin
                act = '{cyc: cyc, rdv: bus.fetch_rd_vld, done: bus.fill_done, abort: bus.fill_abort,
                        en: bus.ram_enable, we: bus.ram_we, adr: bus.ram_adr, di: bus.ram_di};
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_access cyc=%0d en=%b we=%b adr=%h di=%h rdv=%b done=%b abort=%b",
                             act.cyc, act.en, act.we, act.adr, act.di, act.rdv, act.done, act.abort);
                end else begin
                    e = q.pop_front();
                    if (act !== e)
                        begin
                        bad++;
                        $display("FAIL ram_access got cyc=%0d en=%b we=%b adr=%h di=%h rdv=%b done=%b abort=%b exp cyc=%0d en=%b we=%b adr=%h di=%h rdv=%b done=%b abort=%b",
                                 act.cyc, act.en, act.we, act.adr, act.di, act.rdv, act.done, act.abort,
                                 e.cyc, e.en, e.we, e.adr, e.di, e.rdv, e.done, e.abort);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic          r_req;
        logic [AW-1:0] r_adr;
        bus.fetch_req = 0; bus.fetch_adr = '0; bus.fill_start = 0; bus.fill_adr = '0;
        bus.fill_data_vld = 0; bus.fill_data = '0; bus.fill_err = 0;
        reset_l = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.fetch_req = 1;
        #1;
        check_reset_values();
        bus.fetch_req = 0;
        @(posedge clk); #2; reset_l = 1'b1;

        // clear sweep with noise on every input that must be ignored
        for (int i = 0; i < SWEEP; i++)
            step(1'($urandom), 6'($urandom), 1'($urandom), 6'($urandom), 1'($urandom), $urandom, 1'($urandom));
        idle(3);

        // back-to-back line fill at 0x15
        step(0, '0, 1, 6'h15, 0, '0, 0);
        step(0, '0, 0, '0, 1, 32'hA0A0A0A0, 0);
        step(0, '0, 0, '0, 1, 32'hB1B1B1B1, 0);
        step(0, '0, 0, '0, 1, 32'hC2C2C2C2, 0);
        step(0, '0, 0, '0, 1, 32'hD3D3D3D3, 0);
        idle(2);

        // 3-cycle gap after beat 1 with a held fetch of 0x03
        step(0, '0, 1, 6'h2A, 0, '0, 0);
        step(1, 6'h03, 0, '0, 1, 32'h11111111, 0);
        step(1, 6'h03, 0, '0, 1, 32'h22222222, 0);
        for (int i = 0; i < 3; i++) step(1, 6'h03, 0, '0, 0, '0, 0);
        step(1, 6'h03, 0, '0, 1, 32'h33333333, 0);
        step(1, 6'h03, 0, '0, 1, 32'h44444444, 0);
        idle(1);

        // fetch held across four back-to-back beats
        step(0, '0, 1, 6'h3F, 0, '0, 0);
        for (int i = 0; i < BEATS; i++) step(1, 6'h07, 0, '0, 1, 32'h55550000 + 32'(i), 0);
        step(1, 6'h07, 0, '0, 0, '0, 0);
        idle(1);

        // bus error with beat 2, then an immediate new fill
        step(0, '0, 1, 6'h08, 0, '0, 0);
        step(0, '0, 0, '0, 1, 32'hE0E0E0E0, 0);
        step(0, '0, 0, '0, 1, 32'hE1E1E1E1, 0);
        step(0, '0, 0, '0, 1, 32'hE2E2E2E2, 1);
        step(0, '0, 1, 6'h0C, 0, '0, 0);
        for (int i = 0; i < BEATS; i++) step(0, '0, 0, '0, 1, 32'hF0F0F0F0 ^ 32'(i), 0);
        idle(2);

        // random traffic; a stalled fetch keeps its address
        r_req = 0; r_adr = '0;
        for (int i = 0; i < 500; i++) begin
            if (!r_req || m_last_g) begin
                r_req = 1'($urandom_range(0, 1));
                r_adr = 6'($urandom);
            end
            step(r_req, r_adr, ($urandom_range(0, 7) == 0), 6'($urandom),
                 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 29) == 0));
        end
        idle(2);

        // reset pulsed during beat 1 of a fill
        step(0, '0, 1, 6'h20, 0, '0, 0);
        step(0, '0, 0, '0, 1, 32'h12345678, 0);
        @(negedge clk);
        bus.fill_data_vld = 1; bus.fill_data = 32'h9ABCDEF0; bus.fetch_req = 1;
        reset_l = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        repeat (2) @(posedge clk);
        #2; reset_l = 1'b1;
        for (int i = 0; i < SWEEP; i++) step(0, '0, 0, '0, 1, $urandom, 0);
        idle(3);

        check("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icram_fill_ctl.md
Name: icram_fill_ctl

Overview:
Controller in front of the instruction-cache data RAM. It sequences every RAM access:
- post-reset clear sweep
- 4-beat line fills from the memory interface, written one 32-bit half-doubleword per cycle
- fetch reads, arbitrated against fill writes cycle by cycle

It sits between the fetch unit / bus interface and the icram array, and owns the array's adr/di/we/enable pins.

Parameters:
IC_MSB, 8, MSB of the doubleword address; the array holds 2^(IC_MSB-2) doublewords.
BEATS, 4, 32-bit beats per line; must be an even power of 2; a line is BEATS/2 doublewords.

Ports:
clk  input  1  clock; all state changes on posedge
reset_l  input  1  asynchronous active-low reset
fetch_req  input  1  fetch unit requests a doubleword read
fetch_adr  input  IC_MSB-2  doubleword address of the fetch
fetch_gnt  output  1  combinational; read accepted this cycle
fetch_rd_vld  output  1  RAM do[63:0] holds the granted read data this cycle
fill_start  input  1  begin a line fill
fill_adr  input  IC_MSB-2  doubleword address of the line; low log2(BEATS/2) bits ignored, treated as 0
fill_data_vld  input  1  fill_data carries the next beat
fill_data  input  32  beat data, first beat = most significant word of the line
fill_err  input  1  bus error; abort the fill
fill_busy  output  1  fill in progress
fill_done  output  1  one-cycle pulse; last beat written
fill_abort  output  1  one-cycle pulse; fill terminated by fill_err
init_done  output  1  clear sweep finished; stays high until reset
ram_adr  output  IC_MSB-2  to array adr[IC_MSB:3]
ram_di  output  32  to array di
ram_we  output  2  [1] = write upper word (bytes 0-3), [0] = write lower word (bytes 4-7); never both set
ram_enable  output  1  to array enable

Behaviour:
- Reset (async, reset_l=0):
  - state=INIT, sweep counter=0
  - ram_adr=0, ram_di=0, ram_we=0, ram_enable=0
  - fill_busy=0, fill_done=0, fill_abort=0, fetch_rd_vld=0, init_done=0
- All ram_* outputs and fetch_rd_vld are registered: a decision made in cycle N drives the array in cycle N+1.
- States: INIT, IDLE, FILL.
- INIT:
  - Each cycle issue one write of 32'h0: ram_adr=cnt>>1, ram_we = cnt[0] ? 2'b01 : 2'b10.
  - cnt runs 0..2^(IC_MSB-1)-1, i.e. 128 cycles at the default.
  - After the last write: init_done=1, go to IDLE.
  - fetch_gnt=0 throughout; fill_start is ignored.
- IDLE:
  - fill_start=1 -> latch the line base address, beat index b=0, fill_busy=1 next cycle, go to FILL.
  - Fetch arbitration is as in FILL, with no write contending.
- FILL:
  - Each cycle with fill_data_vld=1 accepts beat b:
    - ram_adr = base + (b>>1)
    - ram_di = fill_data
    - ram_we = b[0] ? 2'b01 : 2'b10
    - ram_enable=1
    - b increments.
  - After beat BEATS-1 is accepted: state returns to IDLE and fill_busy=0 on the next edge; fill_done pulses in the cycle that write is driven to the array.
  - Gaps (fill_data_vld=0) are legal and of unbounded length.
  - fill_start while busy is ignored.
- fill_err in FILL:
  - Takes priority over fill_data_vld the same cycle; that beat is not written.
  - Go to IDLE with fill_busy=0; fill_abort pulses next cycle; fill_done never pulses.
  - Beats already written stay in the array.
  - fill_err outside FILL is ignored.
- Fetch arbitration:
  - fetch_gnt = fetch_req & (state!=INIT) & ~(state==FILL & fill_data_vld & ~fill_err).
  - Grant in cycle N -> cycle N+1: ram_adr=fetch_adr, ram_we=0, ram_enable=1, fetch_rd_vld=1.
  - Fill writes always win; a stalled fetch holds fetch_req and fetch_adr.
- Idle cycles (no write, no grant): ram_enable=0, ram_we=0, ram_adr and ram_di hold their last values.
- Reset mid-fill or mid-sweep: immediate return to INIT; the sweep restarts from 0; the partial fill is discarded.
- Address arithmetic: base + (b>>1) never carries out of the line; all fields are modulo 2^(IC_MSB-2).

Test Plan:
- Release reset -> exactly 128 writes of 0 at ram_adr 0..63, alternating ram_we 10/01; init_done rises on the cycle after the last write; fetch_gnt=0 throughout INIT.
- fill_start with fill_adr=6'h15, then 4 back-to-back beats A0A0A0A0, B1B1B1B1, C2C2C2C2, D3D3D3D3:
  - writes at adr 14/we10, 14/we01, 15/we10, 15/we01, in that order
  - fill_done pulses once; fill_busy low the following cycle.
- Fill with a 3-cycle gap after beat 1, fetch_req held with fetch_adr=6'h03:
  - fetch_gnt=1 only in the gap cycles
  - each grant is followed next cycle by ram_we=0, ram_adr=03, fetch_rd_vld=1.
- fetch_req held while beats arrive every cycle -> fetch_gnt=0 for all 4 beat cycles; granted in the first cycle after the last beat.
- fill_err asserted together with beat 2 -> only beats 0 and 1 are written; fill_abort pulses; no fill_done; a new fill_start is accepted on the next cycle.
- reset_l pulsed low during beat 1 of a fill -> outputs return to reset values immediately; a full 128-cycle sweep follows; no further fill writes occur.
